alarm_clock_multi: RTL and testbench

- Parametrised successor to the single-alarm clock: 24 h timekeeper with BCD load/display and a prescaler-generated 1 s tick.
- NUM_ALARMS independently enabled alarm slots, snooze, and ring auto-timeout.
- Feeds the display/buzzer stage; time and alarm setting come from the same BCD inputs as before.

---
 rtl/alarm_clock_multi.sv | 198 +++++++++++++++++++
 tb/tb_alarm_clock_multi.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_multi.sv
// rtl/alarm_clock_multi.sv - 24 h BCD clock with NUM_ALARMS alarm slots, snooze and ring timeout
// Time and slots are stored in binary; BCD conversion happens only on the output side.
module alarm_clock_multi #(
    parameter int CLK_DIV      = 10,
    parameter int NUM_ALARMS   = 4,
    parameter int SEL_W        = 2,
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [SEL_W-1:0]      al_sel,
    input  logic [NUM_ALARMS-1:0] AL_ON,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    output logic                  Alarm,
    output logic [SEL_W-1:0]      alarm_id,
    output logic                  snoozed,
    output logic                  ld_err,
    output logic                  tick_1s,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);
    localparam int PS_W  = $clog2(CLK_DIV);
    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_MAX_MIN * 60);
    localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t           r_state;
    logic [PS_W-1:0]  r_ps;
    logic [4:0]       r_hour;
    logic [5:0]       r_min, r_sec;
    logic [4:0]       r_al_h [NUM_ALARMS];
    logic [5:0]       r_al_m [NUM_ALARMS];
    logic [SEL_W-1:0] r_id;
    logic [CNT_W-1:0] r_ring_cnt, r_snz_cnt;
    logic             r_alarm, r_snoozed, r_ld_err;

    logic [5:0] w_in_hour;
    logic [7:0] w_in_min;
    logic       w_valid, w_ld_t, w_ld_a, w_tick;
    logic       w_sec_wrap, w_min_wrap, w_carry, w_hit, w_id_on;
    logic [5:0] w_nx_min;
    logic [4:0] w_nx_hour;
    logic [SEL_W-1:0] w_hit_id;
    logic [4:0] w_h_tens, w_h_units;
    logic [5:0] w_m_tens, w_m_units, w_s_tens, w_s_units;

    assign w_in_hour = {4'b0, H_in1} * 6'd10 + {2'b0, H_in0};
    assign w_in_min  = {4'b0, M_in1} * 8'd10 + {4'b0, M_in0};
    assign w_valid   = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) && (w_in_hour <= 6'd23);
    assign w_ld_t    = LD_time && w_valid;
    assign w_ld_a    = LD_alarm && w_valid;
    assign w_tick    = (r_ps == PS_W'(CLK_DIV - 1));

    assign w_sec_wrap = (r_sec == 6'd59);
    assign w_min_wrap = (r_min == 6'd59);
    assign w_nx_min   = w_sec_wrap ? (w_min_wrap ? 6'd0 : r_min + 6'd1) : r_min;
    assign w_nx_hour  = (w_sec_wrap && w_min_wrap) ? ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1) : r_hour;
    // A load in the same cycle wins over the tick, so it can never raise an alarm.
    assign w_carry    = w_tick && w_sec_wrap && !w_ld_t;
    assign w_id_on    = AL_ON[r_id];

    always_comb begin
        w_hit    = 1'b0;
        w_hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (AL_ON[i] && r_al_h[i] == w_nx_hour && r_al_m[i] == w_nx_min) begin
                w_hit    = 1'b1;
                w_hit_id = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ps     <= '0;
            r_hour   <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_ld_err <= 1'b0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_al_h[i] <= '0;
                r_al_m[i] <= '0;
            end
        end else begin
            r_ld_err <= (LD_time || LD_alarm) && !w_valid;
            if (w_ld_t) begin
                r_hour <= w_in_hour[4:0];
                r_min  <= w_in_min[5:0];
                r_sec  <= '0;
                r_ps   <= '0;
            end else begin
                r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
                if (w_tick) begin
                    r_sec  <= w_sec_wrap ? 6'd0 : r_sec + 6'd1;
                    r_min  <= w_nx_min;
                    r_hour <= w_nx_hour;
                end
            end
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (w_ld_a && al_sel == SEL_W'(i)) begin
                    r_al_h[i] <= w_in_hour[4:0];
                    r_al_m[i] <= w_in_min[5:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_id       <= '0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_alarm    <= 1'b0;
            r_snoozed  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_carry && w_hit) begin
                        r_state    <= RINGING;
                        r_id       <= w_hit_id;
                        r_ring_cnt <= RING_LOAD;
                        r_alarm    <= 1'b1;
                    end
                end
                RINGING: begin
                    if (STOP_al || !w_id_on) begin
                        r_state <= IDLE;
                        r_alarm <= 1'b0;
                    end else if (SNOOZE) begin
                        r_state   <= SNOOZED;
                        r_snz_cnt <= SNZ_LOAD;
                        r_alarm   <= 1'b0;
                        r_snoozed <= 1'b1;
                    end else if (w_tick) begin
                        if (r_ring_cnt == CNT_W'(1)) begin
                            r_state <= IDLE;
                            r_alarm <= 1'b0;
                        end
                        r_ring_cnt <= r_ring_cnt - CNT_W'(1);
                    end
                end
                SNOOZED: begin
                    if (STOP_al || !w_id_on) begin
                        r_state   <= IDLE;
                        r_snoozed <= 1'b0;
                    end else if (w_tick) begin
                        if (r_snz_cnt == CNT_W'(1)) begin
                            r_state    <= RINGING;
                            r_ring_cnt <= RING_LOAD;
                            r_alarm    <= 1'b1;
                            r_snoozed  <= 1'b0;
                        end
                        r_snz_cnt <= r_snz_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_alarm   <= 1'b0;
                    r_snoozed <= 1'b0;
                end
            endcase
        end
    end

    assign w_h_tens  = r_hour / 5'd10;
    assign w_h_units = r_hour % 5'd10;
    assign w_m_tens  = r_min / 6'd10;
    assign w_m_units = r_min % 6'd10;
    assign w_s_tens  = r_sec / 6'd10;
    assign w_s_units = r_sec % 6'd10;

    assign H_out1   = w_h_tens[1:0];
    assign H_out0   = w_h_units[3:0];
    assign M_out1   = w_m_tens[3:0];
    assign M_out0   = w_m_units[3:0];
    assign S_out1   = w_s_tens[3:0];
    assign S_out0   = w_s_units[3:0];
    assign Alarm    = r_alarm;
    assign snoozed  = r_snoozed;
    assign alarm_id = r_id;
    assign ld_err   = r_ld_err;
    assign tick_1s  = w_tick;
endmodule

// File: tb/tb_alarm_clock_multi.sv
// tb/tb_alarm_clock_multi.sv - self-checking bench for alarm_clock_multi
module tb_alarm_clock_multi;
    localparam int CLK_DIV = 4, NUM_ALARMS = 4, SEL_W = 2, SNOOZE_MIN = 1, RING_MAX_MIN = 2;

    logic clk, reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic LD_time, LD_alarm, STOP_al, SNOOZE;
    logic [SEL_W-1:0] al_sel;
    logic [NUM_ALARMS-1:0] AL_ON;
    logic Alarm, snoozed, ld_err, tick_1s;
    logic [SEL_W-1:0] alarm_id;
    logic [1:0] H_out1;
    logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

    alarm_clock_multi #(
        .CLK_DIV(CLK_DIV), .NUM_ALARMS(NUM_ALARMS), .SEL_W(SEL_W),
        .SNOOZE_MIN(SNOOZE_MIN), .RING_MAX_MIN(RING_MAX_MIN)
    ) dut (
        .clk(clk), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .Alarm(Alarm), .alarm_id(alarm_id), .snoozed(snoozed), .ld_err(ld_err), .tick_1s(tick_1s),
        .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
        .S_out1(S_out1), .S_out0(S_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        lt;
        logic        la;
        logic [1:0]  sel;
        logic [1:0]  h1;
        logic [3:0]  h0, m1, m0;
        logic        e_err;
        logic [15:0] e_hm;
    } vec_t;

    typedef struct {
        logic        err;
        logic [15:0] hm;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    function automatic vec_t mk(logic lt, logic la, logic [1:0] sel, logic [1:0] h1,
                                logic [3:0] h0, logic [3:0] m1, logic [3:0] m0,
                                logic e_err, logic [15:0] e_hm);
        vec_t v;
        v.lt = lt; v.la = la; v.sel = sel; v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0;
        v.e_err = e_err; v.e_hm = e_hm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] cur_time();
        return {2'b0, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (!tick_1s && guard < 2 * CLK_DIV) begin
                step();
                guard++;
            end
            if (!tick_1s) begin
                checks++;
                errors++;
                $display("FAIL tick_timeout: got no tick within %0d cycles expected a tick", 2 * CLK_DIV);
                return;
            end
            step();
        end
    endtask

    task automatic set_in(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
        H_in1 = h1; H_in0 = h0; M_in1 = m1; M_in0 = m0;
    endtask

    task automatic load_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
        set_in(h1, h0, m1, m0);
        LD_time = 1'b1;
        step();
        LD_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0);
        set_in(h1, h0, m1, m0);
        al_sel = sel;
        LD_alarm = 1'b1;
        step();
        LD_alarm = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_alarm"}, Alarm, 0);
        check({tag, "_snoozed"}, snoozed, 0);
    endtask

    initial begin
        exp_t e;
        int guard;
        reset = 1'b1; LD_time = 1'b0; LD_alarm = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
        al_sel = '0; AL_ON = '0;
        set_in(0, 0, 0, 0);

        vecs[0] = mk(1, 0, 0, 2, 5, 0, 0,  1, 16'h1234);
        vecs[1] = mk(0, 1, 0, 0, 0, 0, 10, 1, 16'h1234);
        vecs[2] = mk(1, 0, 0, 1, 2, 6, 0,  1, 16'h1234);
        vecs[3] = mk(1, 0, 0, 0, 9, 5, 9,  0, 16'h0959);
        vecs[4] = mk(1, 0, 0, 2, 4, 0, 0,  1, 16'h0959);
        vecs[5] = mk(1, 0, 0, 1, 10, 0, 0, 1, 16'h0959);
        vecs[6] = mk(1, 0, 0, 2, 3, 4, 5,  0, 16'h2345);
        vecs[7] = mk(1, 1, 3, 0, 7, 1, 5,  0, 16'h0715);
        vecs[8] = mk(1, 1, 3, 2, 0, 9, 9,  1, 16'h0715);

        // Reset state and prescaler phase
        step(); step();
        reset = 1'b0;
        check("rst_alarm", Alarm, 0);
        check("rst_id", alarm_id, 0);
        check("rst_snoozed", snoozed, 0);
        check("rst_ld_err", ld_err, 0);
        check("rst_tick", tick_1s, 0);
        check("rst_time", cur_time(), 24'h000000);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("tick_cycle%0d", c), tick_1s, (c == 3) ? 1 : 0);
        end
        check("time_after_first_tick", cur_time(), 24'h000001);

        // Day rollover
        load_time(2, 3, 5, 9);
        check("load_2359", cur_time(), 24'h235900);
        wait_ticks(59);
        check("at_235959", cur_time(), 24'h235959);
        wait_ticks(1);
        check("rollover", cur_time(), 24'h000000);

        // LD_time in the same cycle as a tick
        guard = 0;
        while (!tick_1s && guard < 2 * CLK_DIV) begin step(); guard++; end
        check("tick_seen_for_coincide", tick_1s, 1);
        load_time(1, 2, 3, 4);
        check("load_on_tick", cur_time(), 24'h123400);
        check("load_on_tick_ps_reset", tick_1s, 0);

        // Load validity table through the scoreboard
        for (int v = 0; v < 9; v++) begin
            set_in(vecs[v].h1, vecs[v].h0, vecs[v].m1, vecs[v].m0);
            al_sel = vecs[v].sel;
            LD_time = vecs[v].lt;
            LD_alarm = vecs[v].la;
            e.err = vecs[v].e_err;
            e.hm = vecs[v].e_hm;
            sb.push_back(e);
            step();
            LD_time = 1'b0;
            LD_alarm = 1'b0;
            e = sb.pop_front();
            check($sformatf("vec%0d_ld_err", v), ld_err, e.err);
            check($sformatf("vec%0d_hm", v), cur_time() >> 8, {8'h0, e.hm});
            step();
            check($sformatf("vec%0d_err_pulse", v), ld_err, 0);
        end

        // Trigger with all slots disabled, then enabled
        load_alarm(1, 0, 7, 3, 0);
        load_alarm(2, 0, 7, 3, 0);
        AL_ON = 4'b0000;
        load_time(0, 7, 2, 9);
        wait_ticks(60);
        check("off_time", cur_time(), 24'h073000);
        check("off_no_alarm", Alarm, 0);

        AL_ON = 4'b0110;
        load_time(0, 7, 2, 9);
        wait_ticks(59);
        check("pre_trigger_alarm", Alarm, 0);
        wait_ticks(1);
        check("trig_alarm", Alarm, 1);
        check("trig_id_lowest", alarm_id, 1);
        check("trig_time", cur_time(), 24'h073000);

        // Snooze and re-ring
        SNOOZE = 1'b1;
        step();
        SNOOZE = 1'b0;
        check("snz_alarm", Alarm, 0);
        check("snz_flag", snoozed, 1);
        wait_ticks(59);
        check("snz_hold", snoozed, 1);
        wait_ticks(1);
        check("rering_alarm", Alarm, 1);
        check("rering_snoozed", snoozed, 0);
        check("rering_id", alarm_id, 1);

        // STOP_al beats SNOOZE
        STOP_al = 1'b1; SNOOZE = 1'b1;
        step();
        STOP_al = 1'b0; SNOOZE = 1'b0;
        check_idle_outputs("stop");

        // Ring auto-timeout
        load_time(0, 7, 2, 9);
        wait_ticks(60);
        check("to_ring", Alarm, 1);
        wait_ticks(119);
        check("to_still_ring", Alarm, 1);
        wait_ticks(1);
        check_idle_outputs("timeout");

        // Only slot 2 enabled, then disable it mid-ring
        AL_ON = 4'b0100;
        load_time(0, 7, 2, 9);
        wait_ticks(60);
        check("slot2_alarm", Alarm, 1);
        check("slot2_id", alarm_id, 2);
        AL_ON = 4'b0000;
        step();
        check_idle_outputs("alon_clear");

        // Reset while ringing
        AL_ON = 4'b0110;
        load_time(0, 7, 2, 9);
        wait_ticks(60);
        check("pre_reset_alarm", Alarm, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_alarm", Alarm, 0);
        check("mid_rst_id", alarm_id, 0);
        check("mid_rst_snoozed", snoozed, 0);
        check("mid_rst_ld_err", ld_err, 0);
        check("mid_rst_tick", tick_1s, 0);
        check("mid_rst_time", cur_time(), 24'h000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
